// File: rtl/riscv_harness_pkg.sv
// Shared types and constants for the RISC-V self-test harness.
package riscv_harness_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/riscv_selftest_harness_if.sv
// Memory-side buses of the harness: program ROM, instruction-memory write port,
// register debug read port and expected-value ROM.
interface riscv_selftest_harness_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 10
);
  logic [IMEM_AW-1:0] prog_addr;
  logic [XLEN-1:0]    prog_data;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_wdata;
  logic [4:0]         dbg_reg_addr;
  logic [XLEN-1:0]    dbg_reg_data;
  logic [4:0]         exp_addr;
  logic [XLEN-1:0]    exp_data;

  modport master (
    output prog_addr, input prog_data,
    output imem_we, output imem_addr, output imem_wdata,
    output dbg_reg_addr, input dbg_reg_data,
    output exp_addr, input exp_data
  );

  modport slave (
    input prog_addr, output prog_data,
    input imem_we, input imem_addr, input imem_wdata,
    input dbg_reg_addr, output dbg_reg_data,
    input exp_addr, output exp_data
  );
endinterface

// File: rtl/riscv_selftest_harness_checker.sv
// Register-compare engine: walks x0..x(CHECK_REGS-1) while check_en is high and
// counts mismatches. RISCV_HARNESS_FAIL_CAPTURE_EN adds first-mismatch capture.
module harness_checker
  import riscv_harness_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int CHECK_REGS = 14,
  localparam int FCW       = $clog2(CHECK_REGS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              check_en,
  input  logic [XLEN-1:0]   act_data,
  input  logic [XLEN-1:0]   exp_data,
  output logic [REG_AW-1:0] idx,
  output logic              check_last,
  output logic [FCW-1:0]    fail_count
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
  ,
  output logic [REG_AW-1:0] fail_idx,
  output logic [XLEN-1:0]   fail_value
`endif
);

  logic [REG_AW-1:0] idx_q, idx_d;
  logic [FCW-1:0]    fail_count_q, fail_count_d;
  logic              mismatch;

  assign mismatch   = (act_data != exp_data);
  assign check_last = (idx_q == REG_AW'(CHECK_REGS - 1));
  assign idx        = idx_q;
  assign fail_count = fail_count_q;

  always_comb begin
    idx_d        = idx_q;
    fail_count_d = fail_count_q;
    if (clear) begin
      idx_d        = '0;
      fail_count_d = '0;
    end else if (check_en) begin
      // Index parks on the last register rather than wrapping.
      if (!check_last) idx_d = idx_q + REG_AW'(1);
      if (mismatch && (fail_count_q != FCW'(CHECK_REGS)))
        fail_count_d = fail_count_q + FCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      fail_count_q <= '0;
    end else begin
      idx_q        <= idx_d;
      fail_count_q <= fail_count_d;
    end
  end

`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
  logic [REG_AW-1:0] fail_idx_q, fail_idx_d;
  logic [XLEN-1:0]   fail_value_q, fail_value_d;

  always_comb begin
    fail_idx_d   = fail_idx_q;
    fail_value_d = fail_value_q;
    if (clear) begin
      fail_idx_d   = '0;
      fail_value_d = '0;
    end else if (check_en && mismatch && (fail_count_q == '0)) begin
      fail_idx_d   = idx_q;
      fail_value_d = act_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_idx_q   <= '0;
      fail_value_q <= '0;
    end else begin
      fail_idx_q   <= fail_idx_d;
      fail_value_q <= fail_value_d;
    end
  end

  assign fail_idx   = fail_idx_q;
  assign fail_value = fail_value_q;
`endif

endmodule

// File: rtl/riscv_selftest_harness.sv
// Self-test sequencer: load program, run core to halt/timeout, drain, check registers.
// Optional first-mismatch capture ports: define RISCV_HARNESS_FAIL_CAPTURE_EN.
module riscv_selftest_harness
  import riscv_harness_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int PROG_WORDS   = 16,
  parameter int IMEM_AW      = 10,
  parameter int CHECK_REGS   = 14,
  parameter int TIMEOUT      = 100,
  parameter int DRAIN_CYCLES = 5,
  parameter int REQUIRE_HALT = 0,
  localparam int FCW         = $clog2(CHECK_REGS + 1),
  localparam int CCW         = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  riscv_selftest_harness_if.master   bus,
  output logic                       core_rst_n,
  output logic                       core_freeze,
  input  logic                       core_halted,
  output logic                       done,
  output logic                       pass,
  output logic                       timed_out,
  output logic [FCW-1:0]             fail_count,
  output logic [CCW-1:0]             cycle_count
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
  ,
  output logic [REG_AW-1:0]          fail_idx,
  output logic [XLEN-1:0]            fail_value
`endif
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] load_idx_q, load_idx_d;
  logic [CCW-1:0]     cycle_count_q, cycle_count_d;
  logic               timed_out_q, timed_out_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic               results_clr;
  logic               check_en;
  logic               check_last;
  logic [REG_AW-1:0]  chk_idx;

  always_comb begin
    state_d       = state_q;
    load_idx_d    = load_idx_q;
    cycle_count_d = cycle_count_q;
    timed_out_d   = timed_out_q;
    drain_cnt_d   = drain_cnt_q;
    results_clr   = 1'b0;
    check_en      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          results_clr   = 1'b1;
          load_idx_d    = '0;
          cycle_count_d = '0;
          timed_out_d   = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (load_idx_q == IMEM_AW'(PROG_WORDS - 1)) state_d = RUN;
        else load_idx_d = load_idx_q + IMEM_AW'(1);
      end
      RUN: begin
        cycle_count_d = cycle_count_q + CCW'(1);
        // Halt takes priority over a timeout landing on the same cycle.
        if (core_halted) begin
          drain_cnt_d = '0;
          state_d     = (DRAIN_CYCLES == 0) ? CHECK : DRAIN;
        end else if (cycle_count_d == CCW'(TIMEOUT)) begin
          timed_out_d = 1'b1;
          state_d     = CHECK;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) state_d = CHECK;
        else drain_cnt_d = drain_cnt_q + DW'(1);
      end
      CHECK: begin
        check_en = 1'b1;
        if (check_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      load_idx_q    <= '0;
      cycle_count_q <= '0;
      timed_out_q   <= 1'b0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      load_idx_q    <= load_idx_d;
      cycle_count_q <= cycle_count_d;
      timed_out_q   <= timed_out_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  harness_checker #(
    .XLEN       (XLEN),
    .CHECK_REGS (CHECK_REGS)
  ) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (results_clr),
    .check_en   (check_en),
    .act_data   (bus.dbg_reg_data),
    .exp_data   (bus.exp_data),
    .idx        (chk_idx),
    .check_last (check_last),
    .fail_count (fail_count)
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
    ,
    .fail_idx   (fail_idx),
    .fail_value (fail_value)
`endif
  );

  assign bus.prog_addr    = load_idx_q;
  assign bus.imem_addr    = load_idx_q;
  assign bus.imem_we      = (state_q == LOAD);
  assign bus.imem_wdata   = bus.prog_data;
  assign bus.dbg_reg_addr = chk_idx;
  assign bus.exp_addr     = chk_idx;

  // Core stays out of reset from RUN onward so CHECK sees the retired state.
  assign core_rst_n  = (state_q != IDLE) && (state_q != LOAD);
  assign core_freeze = (state_q != RUN) && (state_q != DRAIN);

  assign done        = (state_q == DONE);
  assign pass        = done && (fail_count == '0) && !((REQUIRE_HALT != 0) && timed_out_q);
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_riscv_selftest_harness.sv
// Directed bench for riscv_selftest_harness: two instances (REQUIRE_HALT=0 and =1)
// share stimulus; scenario table plus loader, start-ignore and async-reset sequences.
module tb_riscv_selftest_harness;
  import riscv_harness_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_halted = 1'b0;

  always #5 clk = ~clk;

  riscv_selftest_harness_if #(.XLEN(32), .IMEM_AW(10)) if_s ();
  riscv_selftest_harness_if #(.XLEN(32), .IMEM_AW(10)) if_h ();

  logic [31:0] core_regs [32];
  logic [31:0] exp_regs  [32];

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    rom_word = (a == 10'd3) ? 32'h0020_8233 : (32'hC0DE_0000 | {22'd0, a});
  endfunction

  assign if_s.prog_data    = rom_word(if_s.prog_addr);
  assign if_h.prog_data    = rom_word(if_h.prog_addr);
  assign if_s.dbg_reg_data = core_regs[if_s.dbg_reg_addr];
  assign if_h.dbg_reg_data = core_regs[if_h.dbg_reg_addr];
  assign if_s.exp_data     = exp_regs[if_s.exp_addr];
  assign if_h.exp_data     = exp_regs[if_h.exp_addr];

  logic       s_core_rst_n, s_core_freeze, s_done, s_pass, s_timed_out;
  logic       h_core_rst_n, h_core_freeze, h_done, h_pass, h_timed_out;
  logic [3:0] s_fail_count, h_fail_count;
  logic [6:0] s_cycle_count, h_cycle_count;
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
  logic [4:0]  s_fail_idx, h_fail_idx;
  logic [31:0] s_fail_value, h_fail_value;
`endif

  riscv_selftest_harness #(.REQUIRE_HALT(0)) u_soft (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (if_s),
    .core_rst_n  (s_core_rst_n),
    .core_freeze (s_core_freeze),
    .core_halted (core_halted),
    .done        (s_done),
    .pass        (s_pass),
    .timed_out   (s_timed_out),
    .fail_count  (s_fail_count),
    .cycle_count (s_cycle_count)
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
    ,
    .fail_idx    (s_fail_idx),
    .fail_value  (s_fail_value)
`endif
  );

  riscv_selftest_harness #(.REQUIRE_HALT(1)) u_hard (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (if_h),
    .core_rst_n  (h_core_rst_n),
    .core_freeze (h_core_freeze),
    .core_halted (core_halted),
    .done        (h_done),
    .pass        (h_pass),
    .timed_out   (h_timed_out),
    .fail_count  (h_fail_count),
    .cycle_count (h_cycle_count)
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
    ,
    .fail_idx    (h_fail_idx),
    .fail_value  (h_fail_value)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"},      {31'd0, s_done}, 0);
    chk({tag, "_pass"},      {31'd0, s_pass}, 0);
    chk({tag, "_timed_out"}, {31'd0, s_timed_out}, 0);
    chk({tag, "_fail_cnt"},  {28'd0, s_fail_count}, 0);
    chk({tag, "_cycle_cnt"}, {25'd0, h_cycle_count}, 0);
    chk({tag, "_core_rst"},  {31'd0, h_core_rst_n}, 0);
    chk({tag, "_freeze"},    {31'd0, h_core_freeze}, 1);
    chk({tag, "_imem_we"},   {31'd0, if_h.imem_we}, 0);
    chk({tag, "_imem_addr"}, {22'd0, if_h.imem_addr}, 0);
    chk({tag, "_dbg_addr"},  {27'd0, if_h.dbg_reg_addr}, 0);
    chk({tag, "_state"},     {29'd0, u_hard.state_q}, {29'd0, IDLE});
  endtask

  typedef struct {
    int          halt_cyc;   // 0 = never halt
    int          bad0_idx;
    logic [31:0] bad0_val;
    int          bad1_idx;
    logic [31:0] bad1_val;
    logic        soft_pass;
    logic        hard_pass;
    logic        timed;
    int          cyc;
    int          fails;
    int          fidx;
    logic [31:0] fval;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int k);
    int n;
    int lat_exp;
    for (int r = 0; r < 32; r++) core_regs[r] = exp_regs[r];
    core_regs[vecs[k].bad0_idx] = vecs[k].bad0_val;
    core_regs[vecs[k].bad1_idx] = vecs[k].bad1_val;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("clr_done",  {31'd0, s_done}, 0);
    chk("clr_cycle", {25'd0, s_cycle_count}, 0);
    chk("clr_fails", {28'd0, h_fail_count}, 0);
    n = 0;
    while (!h_core_rst_n && n < 100) begin @(negedge clk); n++; end
    chk("run_entry", {31'd0, h_core_rst_n}, 1);
    if (vecs[k].halt_cyc != 0) begin
      repeat (vecs[k].halt_cyc - 1) @(negedge clk);
      core_halted = 1'b1;
      @(negedge clk);
      core_halted = 1'b0;
      lat_exp = 5 + 14;
    end else begin
      lat_exp = 100 + 14;
    end
    n = 0;
    while (!(s_done && h_done) && n < 400) begin @(negedge clk); n++; end
    chk("done_latency", n, lat_exp);
    chk("soft_done",  {31'd0, s_done}, 1);
    chk("soft_pass",  {31'd0, s_pass}, {31'd0, vecs[k].soft_pass});
    chk("hard_pass",  {31'd0, h_pass}, {31'd0, vecs[k].hard_pass});
    chk("timed_out",  {31'd0, s_timed_out}, {31'd0, vecs[k].timed});
    chk("h_timed",    {31'd0, h_timed_out}, {31'd0, vecs[k].timed});
    chk("cycle_cnt",  {25'd0, s_cycle_count}, vecs[k].cyc);
    chk("fail_cnt",   {28'd0, s_fail_count}, vecs[k].fails);
    chk("h_fail_cnt", {28'd0, h_fail_count}, vecs[k].fails);
`ifdef RISCV_HARNESS_FAIL_CAPTURE_EN
    chk("fail_idx",   {27'd0, s_fail_idx}, vecs[k].fidx);
    chk("fail_value", s_fail_value, vecs[k].fval);
`endif
    $display("vec %0d halt=%0d cyc=%0d timed=%0b fails=%0d pass(soft/hard)=%0b/%0b",
             k, vecs[k].halt_cyc, s_cycle_count, s_timed_out, s_fail_count, s_pass, h_pass);
  endtask

  initial begin : main
    int writes;
    bit addr_ok;
    bit rst_low_ok;
    bit after_seen;
    logic after_val;
    logic [31:0] word3;
    int n;

    for (int r = 0; r < 32; r++) exp_regs[r] = 32'd0;
    exp_regs[1] = 32'd10; exp_regs[4] = 32'd30; exp_regs[6] = 32'd63;
    exp_regs[7] = 32'd22; exp_regs[9] = 32'd50; exp_regs[12] = 32'd99;
    for (int r = 0; r < 32; r++) core_regs[r] = exp_regs[r];

    //          halt bad0       bad1        soft  hard  timed cyc fails fidx fval
    vecs[0] = '{0,   31, 32'd0, 31, 32'd0,  1'b1, 1'b0, 1'b1, 100, 0, 0, 32'd0};
    vecs[1] = '{0,   9, 32'd99, 31, 32'd0,  1'b0, 1'b0, 1'b1, 100, 1, 9, 32'd99};
    vecs[2] = '{40,  31, 32'd0, 31, 32'd0,  1'b1, 1'b1, 1'b0, 40,  0, 0, 32'd0};
    vecs[3] = '{100, 31, 32'd0, 31, 32'd0,  1'b1, 1'b1, 1'b0, 100, 0, 0, 32'd0};
    vecs[4] = '{7,   2, 32'd5,  13, 32'd7,  1'b0, 1'b0, 1'b0, 7,   2, 2, 32'd5};
    vecs[5] = '{0,   31, 32'd0, 31, 32'd0,  1'b1, 1'b0, 1'b1, 100, 0, 0, 32'd0};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Loader sequence with a stray start pulse in the middle of LOAD.
    writes = 0; addr_ok = 1'b1; rst_low_ok = 1'b1; after_seen = 1'b0;
    after_val = 1'b0; word3 = 32'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (if_h.imem_we) begin
        if (if_h.imem_addr != 10'(writes) || if_h.prog_addr != 10'(writes)) addr_ok = 1'b0;
        if (writes == 3) word3 = if_h.imem_wdata;
        if (h_core_rst_n) rst_low_ok = 1'b0;
        writes++;
      end else if (!after_seen) begin
        after_seen = 1'b1;
        after_val  = h_core_rst_n;
      end
      start = (c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("load_writes", writes, 16);
    chk("load_addr_seq", {31'd0, addr_ok}, 1);
    chk("load_word3", word3, 32'h0020_8233);
    chk("load_core_rst_low", {31'd0, rst_low_ok}, 1);
    chk("core_rst_after_load", {31'd0, after_val}, 1);
    n = 0;
    while (!s_done && n < 400) begin @(negedge clk); n++; end
    chk("load_run_done", {31'd0, s_done}, 1);
    chk("load_run_cycles", {25'd0, s_cycle_count}, 100);
    chk("load_run_pass", {31'd0, s_pass}, 1);
    $display("loader writes=%0d word3=%h core_rst_after=%0b", writes, word3, after_val);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Asynchronous abort in the middle of RUN.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!h_core_rst_n && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("midrun_freeze", {31'd0, h_core_freeze}, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    $display("abort mid-RUN state=%0d core_rst_n=%0b", u_hard.state_q, h_core_rst_n);
    @(negedge clk); rst_n = 1'b1;
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_selftest_harness.md
Name: riscv_selftest_harness

Overview:
- Synthesizable, parametrised self-checking sequencer for the RISCV32 pipelined core; the successor to hand-written stimulus benches.
- Holds the core in reset and loads PROG_WORDS instruction words from an external program ROM into instruction memory.
- Releases the core, then runs it until halt or timeout and lets the pipeline drain.
- Reads back CHECK_REGS registers through a debug port, compares them against an expected-value ROM, and reports pass/fail, mismatch count and cycle count.

Parameters:
- XLEN, 32, data/register width.
- PROG_WORDS, 16, instruction words loaded (>=1).
- IMEM_AW, 10, instruction-memory address width.
- CHECK_REGS, 14, registers checked, x0..x(CHECK_REGS-1) (1..32).
- TIMEOUT, 100, maximum RUN cycles (>=1).
- DRAIN_CYCLES, 5, cycles allowed after halt for the pipeline to retire.
- REQUIRE_HALT, 0, 1 = timeout counts as failure; 0 = timeout is the normal end of run.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- prog_addr  out  IMEM_AW  program ROM index (combinational ROM).
- prog_data  in  XLEN  program word at prog_addr, same cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  IMEM_AW  write word address.
- imem_wdata  out  XLEN  write data.
- core_rst_n  out  1  core reset, active-low.
- core_freeze  out  1  core clock-enable inhibit.
- core_halted  in  1  core HALTED flag.
- dbg_reg_addr  out  5  register-file read address.
- dbg_reg_data  in  XLEN  combinational read data.
- exp_addr  out  5  expected-value ROM index.
- exp_data  in  XLEN  expected value, same cycle.
- done  out  1  result valid.
- pass  out  1  run passed.
- timed_out  out  1  RUN ended by timeout.
- fail_count  out  $clog2(CHECK_REGS+1)  number of register mismatches.
- cycle_count  out  $clog2(TIMEOUT+1)  RUN cycles consumed.

Behaviour:
- Reset (async, rst_n=0): state IDLE, core_rst_n=0, core_freeze=1, imem_we=0, done=0, pass=0, timed_out=0, fail_count=0, cycle_count=0, all address outputs 0.
- IDLE: core_rst_n=0. On start: clear fail_count, cycle_count, timed_out, done and pass; go to LOAD.
- LOAD: exactly PROG_WORDS cycles. On cycle i: imem_we=1, imem_addr=prog_addr=i, imem_wdata=prog_data; core_rst_n=0. After the last write go to RUN.
- RUN: core_rst_n=1, core_freeze=0. cycle_count increments every RUN cycle.
  - core_halted=1 sampled: go to DRAIN; the count includes that cycle.
  - Otherwise, when cycle_count reaches TIMEOUT: set timed_out=1 and go to CHECK, skipping DRAIN.
- DRAIN: DRAIN_CYCLES cycles with core_freeze=0, then go to CHECK. DRAIN_CYCLES=0 goes straight to CHECK.
- CHECK: core_freeze=1, core_rst_n stays 1 so register state is preserved.
  - CHECK_REGS cycles; on cycle i, dbg_reg_addr=exp_addr=i.
  - fail_count increments when dbg_reg_data != exp_data.
- DONE: done=1, held along with all results.
  - pass = (fail_count==0) && !(REQUIRE_HALT && timed_out).
  - start returns to LOAD, clearing all results first.
- start is ignored in LOAD, RUN, DRAIN and CHECK.
- Boundaries:
  - core_halted and timeout in the same cycle: the halt wins, timed_out=0.
  - fail_count saturates only at CHECK_REGS, which is its natural maximum.
  - Index counters stop at their last value; no wrap.
  - Reset asserted in any state aborts immediately to reset values. No partial results are retained.

Optional Feature:
- Macro: RISCV_HARNESS_FAIL_CAPTURE_EN.
- Defined: adds outputs fail_idx (5) and fail_value (XLEN). These latch the register index and actual value of the first mismatch in CHECK, and are valid when done=1 && fail_count!=0. Both reset to 0 and are cleared on start.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package riscv_harness_pkg: state enum (IDLE, LOAD, RUN, DRAIN, CHECK, DONE), XLEN default, REG_AW=5.
- Sub-module harness_checker: index counter, comparator, fail counter and optional first-fail capture. It is driven by a check_en strobe from the top-level FSM.

Test Plan:
- Loader: PROG_WORDS=16, ROM word 3 = 32'h00208233, start pulse -> imem_we high exactly 16 cycles, addresses 0..15, word 3 written as 00208233. core_rst_n=0 throughout; it rises the cycle after the last write.
- Pass path: REQUIRE_HALT=0, TIMEOUT=100, core model returns x1=10, x4=30, x6=63, x7=22, x9=50, x12=99, matching expected -> timed_out=1, cycle_count=100, done=1, pass=1, fail_count=0.
- Mismatch: expected x9=50, core returns 99 -> pass=0, fail_count=1. With the macro: fail_idx=9, fail_value=99.
- Halt: REQUIRE_HALT=1, core_halted asserted on RUN cycle 40 -> cycle_count=40, 5 DRAIN cycles, then CHECK; timed_out=0, pass=1. Also: halt on RUN cycle 100 -> halt wins, timed_out=0.
- Timeout failure: REQUIRE_HALT=1, halt never asserted, all registers match -> timed_out=1, fail_count=0, pass=0.
- Robustness:
  - start pulsed during LOAD -> ignored, exactly 16 writes.
  - rst_n low mid-RUN -> all outputs at reset values asynchronously, state IDLE.
  - A new start from DONE -> results cleared, rerun produces identical results.
